main_control_fsm: RTL and testbench

//  Multicycle main controller; sits directly upstream of the ALU decoder and drives its ALUOp.

---
 rtl/main_control_fsm.sv | 166 ++++++++++++++++
 tb/tb_main_control_fsm.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multicycle main controller: sequences each instruction through fetch, decode,
// execute and writeback, waits on memory with a timeout, and latches a sticky fault.
module main_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic       ImmBit,
    input  logic       LoadBit,
    input  logic       NoWrite,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemW,
    output logic       RegW,
    output logic       Branch,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       InstrDone,
    output logic       Fault,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    localparam bit             TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             alu_op_q;
    logic             in_wait;
    logic             timeout;

    logic pc_write, ir_write, mem_w, reg_w, branch;

    always_comb begin
        in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
        timeout = TIMEOUT_EN && (wait_cnt == LAST_WAIT) && !MemReady;
    end

    // State register, wait counter and the registered ALUOp
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            alu_op_q <= 1'b0;
        end else begin
            state    <= state_next;
            alu_op_q <= (state_next == S_EXECR) || (state_next == S_EXECI);
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (in_wait && !MemReady) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (MemReady)     state_next = S_DECODE;
                else if (timeout) state_next = S_FAULT;
            end
            S_DECODE: begin
                case (Op)
                    2'b00:   state_next = ImmBit ? S_EXECI : S_EXECR;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FAULT;
                endcase
            end
            S_MEMADR: state_next = LoadBit ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemReady)     state_next = S_MEMWB;
                else if (timeout) state_next = S_FAULT;
            end
            S_MEMWB: state_next = S_FETCH;
            S_MEMWR: begin
                if (MemReady)     state_next = S_FETCH;
                else if (timeout) state_next = S_FAULT;
            end
            S_EXECR, S_EXECI: state_next = NoWrite ? S_FETCH : S_ALUWB;
            S_ALUWB, S_BRANCH: state_next = S_FETCH;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        Fault     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_write  = MemReady;
                ir_write  = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: ALUSrcB = 2'b00;
            S_EXECI: ALUSrcB = 2'b01;
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            S_FAULT: Fault = 1'b1;
            default: Fault = 1'b0;
        endcase
    end

    // Write enables are forced low combinationally while reset is asserted
    assign PCWrite   = pc_write & rst_n;
    assign IRWrite   = ir_write & rst_n;
    assign MemW      = mem_w & rst_n;
    assign RegW      = reg_w & rst_n;
    assign Branch    = branch & rst_n;
    assign ALUOp     = alu_op_q;
    assign InstrDone = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_FAULT);
    assign State     = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// script (state code, inputs, done flag) and the DUT outputs are compared every cycle.
module tb_main_control_fsm;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] Op = 2'b00;
    logic       ImmBit = 1'b0, LoadBit = 1'b0, NoWrite = 1'b0, MemReady = 1'b0;
    logic       PCWrite, IRWrite, AdrSrc, MemW, RegW, Branch, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc;
    logic       ALUOp, InstrDone, Fault;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    main_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .ImmBit(ImmBit), .LoadBit(LoadBit),
        .NoWrite(NoWrite), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .MemW(MemW), .RegW(RegW), .Branch(Branch), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .InstrDone(InstrDone),
        .Fault(Fault), .State(State)
    );

    logic [17:0] obs;
    assign obs = {State, PCWrite, IRWrite, AdrSrc, MemW, RegW, Branch, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUOp, InstrDone, Fault};

    typedef struct {
        logic [1:0] op;
        logic       imm, ld, nw, mr, rstn;
        int         code;
        bit         done;
    } cyc_t;

    cyc_t q[$];

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic logic [17:0] expected(cyc_t c);
        logic pcw, irw, adr, mw, rw, br, sa, aop, flt;
        logic [1:0] sb, rs;
        {pcw, irw, adr, mw, rw, br, sa, aop, flt} = '0;
        sb = 2'b00;
        rs = 2'b00;
        case (c.code)
            0:  begin sa = 1; sb = 2'b10; rs = 2'b10; pcw = c.mr; irw = c.mr; end
            1:  begin sa = 1; sb = 2'b10; rs = 2'b10; end
            2:  sb = 2'b01;
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  sb = 2'b00;
            7:  sb = 2'b01;
            8:  rw = 1;
            9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
            10: flt = 1;
            default: flt = 0;
        endcase
        aop = (c.code == 6) || (c.code == 7);
        if (!c.rstn) {pcw, irw, mw, rw, br} = '0;
        return {4'(c.code), pcw, irw, adr, mw, rw, br, sa, sb, rs, aop, c.done, flt};
    endfunction

    // InstrDone is not judged on reset cycles (the instruction is being aborted)
    function automatic logic [17:0] mask_of(cyc_t c);
        return c.rstn ? 18'h3ffff : 18'h3fffd;
    endfunction

    function automatic void push(int code, logic mr, bit done);
        cyc_t c;
        c.op   = 2'($urandom);
        c.imm  = 1'($urandom);
        c.ld   = 1'($urandom);
        c.nw   = 1'($urandom);
        c.mr   = mr;
        c.rstn = 1'b1;
        c.code = code;
        c.done = done;
        q.push_back(c);
    endfunction

    function automatic void add_reset(int code);
        push(code, 1'($urandom), 1'b0);
        q[q.size()-1].rstn = 1'b0;
    endfunction

    // w not-ready cycles then a ready one; w >= T means the wait runs out into FAULT
    function automatic bit add_wait(int code, int w);
        int n = (w < T) ? w : T;
        for (int i = 0; i < n; i++) push(code, 1'b0, 1'b0);
        if (w >= T) return 1'b1;
        push(code, 1'b1, 1'b0);
        return 1'b0;
    endfunction

    // kind: 0 DP reg, 1 DP imm, 2 load, 3 store, 4 branch, 5 illegal. Returns 1 on fault.
    function automatic bit add_instr(int kind, int wf, int wm, logic nw);
        if (add_wait(0, wf)) return 1'b1;
        push(1, 1'($urandom), 1'b0);
        case (kind)
            0, 1: begin
                q[q.size()-1].op  = 2'b00;
                q[q.size()-1].imm = (kind == 1);
                push((kind == 1) ? 7 : 6, 1'($urandom), nw);
                q[q.size()-1].nw = nw;
                if (!nw) push(8, 1'($urandom), 1'b1);
            end
            2, 3: begin
                q[q.size()-1].op = 2'b01;
                push(2, 1'($urandom), 1'b0);
                q[q.size()-1].ld = (kind == 2);
                if (add_wait((kind == 2) ? 3 : 5, wm)) return 1'b1;
                if (kind == 2) push(4, 1'($urandom), 1'b1);
                else q[q.size()-1].done = 1'b1;
            end
            4: begin
                q[q.size()-1].op = 2'b10;
                push(9, 1'($urandom), 1'b1);
            end
            default: begin
                q[q.size()-1].op = 2'b11;
                return 1'b1;
            end
        endcase
        return 1'b0;
    endfunction

    function automatic void add_fault_tail(int n);
        for (int i = 0; i < n; i++) push(10, 1'($urandom), 1'b0);
        add_reset(10);
    endfunction

    task automatic apply(input cyc_t c);
        @(posedge clk);
        #1;
        Op = c.op; ImmBit = c.imm; LoadBit = c.ld; NoWrite = c.nw;
        MemReady = c.mr; rst_n = c.rstn;
        @(negedge clk);
    endtask

    task automatic test_reset;
        cyc_t c;
        c = '{op: 2'b00, imm: 0, ld: 0, nw: 0, mr: 0, rstn: 0, code: 0, done: 0};
        apply(c);
        apply(c);
        push(0, 1'b0, 1'b0);
        add_reset(0);
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            checks++;
            if ((obs & mask_of(c)) !== (expected(c) & mask_of(c))) begin
                errors++;
                $display("FAIL reset: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
    endtask

    task automatic test_dp_reg;
        cyc_t c;
        int alu_hi = 0, dones = 0;
        void'(add_instr(0, 0, 0, 1'b0));
        while (q.size() > 0) begin
            c = q.pop_front();
            c.mr = 1'b1;
            apply(c);
            alu_hi += int'(ALUOp);
            dones  += int'(InstrDone);
            checks++;
            if (obs !== expected(c)) begin
                errors++;
                $display("FAIL dp_reg: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
        checks++;
        if (alu_hi !== 1) begin
            errors++;
            $display("FAIL dp_reg_aluop_cycles: got %0d want 1", alu_hi);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL dp_reg_instrdone: got %0d want 1", dones);
        end
    endtask

    task automatic test_load_wait;
        cyc_t c;
        int rd_cycles = 0;
        void'(add_instr(2, 0, 3, 1'b0));
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            rd_cycles += int'(State == 4'd3);
            checks++;
            if (obs !== expected(c)) begin
                errors++;
                $display("FAIL load_wait: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
        checks++;
        if (rd_cycles !== 4) begin
            errors++;
            $display("FAIL load_memrd_cycles: got %0d want 4", rd_cycles);
        end
    endtask

    task automatic test_back_to_back;
        cyc_t c;
        int rises = 0, regw = 0;
        logic prev = 1'b0;
        void'(add_instr(1, 0, 0, 1'b1));
        void'(add_instr(1, 0, 0, 1'b1));
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            if (ALUOp && !prev) rises++;
            prev = ALUOp;
            regw += int'(RegW);
            checks++;
            if (obs !== expected(c)) begin
                errors++;
                $display("FAIL back_to_back: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
        checks++;
        if (rises !== 2) begin
            errors++;
            $display("FAIL b2b_aluop_edges: got %0d want 2", rises);
        end
        checks++;
        if (regw !== 0) begin
            errors++;
            $display("FAIL b2b_regw_cycles: got %0d want 0", regw);
        end
    endtask

    task automatic test_illegal_fault;
        cyc_t c;
        int flt = 0;
        void'(add_instr(5, 0, 0, 1'b0));
        add_fault_tail(20);
        push(0, 1'b0, 1'b0);
        add_reset(0);
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            flt += int'(Fault);
            checks++;
            if ((obs & mask_of(c)) !== (expected(c) & mask_of(c))) begin
                errors++;
                $display("FAIL illegal_fault: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
        checks++;
        if (flt !== 21) begin
            errors++;
            $display("FAIL illegal_fault_hold: got %0d want 21", flt);
        end
    endtask

    task automatic test_store_timeout;
        cyc_t c;
        int memw_a = 0, memw_b = 0, flt_b = 0;
        void'(add_instr(3, 0, 15, 1'b0));
        add_fault_tail(1);
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            memw_a += int'(MemW);
            checks++;
            if ((obs & mask_of(c)) !== (expected(c) & mask_of(c))) begin
                errors++;
                $display("FAIL store_timeout: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
        checks++;
        if (memw_a !== 15) begin
            errors++;
            $display("FAIL store_timeout_memw: got %0d want 15", memw_a);
        end
        void'(add_instr(3, 0, 14, 1'b0));
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            memw_b += int'(MemW);
            flt_b  += int'(Fault);
            checks++;
            if (obs !== expected(c)) begin
                errors++;
                $display("FAIL store_last_ready: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
        checks++;
        if (memw_b !== 15 || flt_b !== 0) begin
            errors++;
            $display("FAIL store_last_ready_memw: got memw=%0d fault=%0d want memw=15 fault=0",
                     memw_b, flt_b);
        end
    endtask

    task automatic test_reset_mid_store;
        cyc_t c;
        push(0, 1'b1, 1'b0);
        push(1, 1'($urandom), 1'b0);
        q[q.size()-1].op = 2'b01;
        push(2, 1'($urandom), 1'b0);
        q[q.size()-1].ld = 1'b0;
        for (int i = 0; i < 3; i++) push(5, 1'b0, 1'b0);
        add_reset(5);
        q[q.size()-1].mr = 1'b0;
        // A 14-cycle fetch wait only survives if the abort cleared the counter
        void'(add_instr(4, 14, 0, 1'b0));
        while (q.size() > 0) begin
            c = q.pop_front();
            apply(c);
            checks++;
            if ((obs & mask_of(c)) !== (expected(c) & mask_of(c))) begin
                errors++;
                $display("FAIL reset_mid_store: got %h want %h (code %0d)", obs, expected(c), c.code);
            end
        end
    endtask

    task automatic test_random;
        cyc_t c;
        int kind, r, wf, wm;
        for (int n = 0; n < 80; n++) begin
            r    = $urandom_range(0, 19);
            kind = (r < 19) ? (r % 5) : 5;
            wf   = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 3);
            wm   = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 3);
            if (add_instr(kind, wf, wm, 1'($urandom))) add_fault_tail($urandom_range(1, 3));
            while (q.size() > 0) begin
                c = q.pop_front();
                apply(c);
                checks++;
                if ((obs & mask_of(c)) !== (expected(c) & mask_of(c))) begin
                    errors++;
                    $display("FAIL random[%0d]: got %h want %h (code %0d)",
                             n, obs, expected(c), c.code);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_dp_reg;
        test_load_wait;
        test_back_to_back;
        test_illegal_fault;
        test_store_timeout;
        test_reset_mid_store;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
